// File: rtl/vref_pkg.sv
// Shared constants for the VREF power sequencer: FSM state encoding,
// default cycle counts, and the bandgap-monitor low-run length.
package vref_pkg;

    // State encoding is software visible through seq_state.
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_LDO_UP  = 3'd1,
        ST_VREF_UP = 3'd2,
        ST_ON      = 3'd3,
        ST_PWR_DN  = 3'd4,
        ST_ERR     = 3'd5
    } vref_state_e;

    localparam int LDO_SETTLE_CYC_DEF = 64;
    localparam int BG_TIMEOUT_CYC_DEF = 1024;
    localparam int DN_HOLD_CYC_DEF    = 8;

    // Consecutive synchronized bg-low samples in ON that count as a bandgap loss.
    localparam int BG_MON_LOW_CYC     = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vref_sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module vref_sync2 (
    input  logic vref_pclk,
    input  logic vref_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Two back-to-back flops; r_meta may go metastable, r_q is the settled copy.
    always_ff @(posedge vref_pclk or negedge vref_rst_n) begin
        if (!vref_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/vref_seq_ctrl.sv
// VREF power sequencer: OFF -> LDO_UP -> VREF_UP -> ON, with an ordered
// power-down through PWR_DN and a sticky bandgap-timeout error state.
// Optional feature macro VREF_SEQ_BG_MON_EN: while ON, a run of synchronized
// bandgap-low samples forces ERR. Undefined by default (monitor absent).
module vref_seq_ctrl
    import vref_pkg::*;
#(
    parameter int LDO_SETTLE_CYC = LDO_SETTLE_CYC_DEF,
    parameter int BG_TIMEOUT_CYC = BG_TIMEOUT_CYC_DEF,
    parameter int DN_HOLD_CYC    = DN_HOLD_CYC_DEF
) (
    input  logic       vref_pclk,
    input  logic       vref_rst_n,
    input  logic       req_on,
    input  logic [1:0] req_sc_mode,
    input  logic       err_clr,
    input  logic       bg_flag,
    output logic       ldo_en_o,
    output logic       vref_en_o,
    output logic [1:0] sc_mode_o,
    output logic       vref_ready,
    output logic       timeout_err,
    output logic [2:0] seq_state
);

    // One shared counter sized for the longest phase; it saturates at all-ones.
    localparam int CNT_MAX = max3(LDO_SETTLE_CYC, BG_TIMEOUT_CYC, DN_HOLD_CYC);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LDO_LAST = CNT_W'(LDO_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] BG_LAST  = CNT_W'(BG_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] DN_LAST  = CNT_W'(DN_HOLD_CYC - 1);

    logic              w_bg_s;
    vref_state_e       r_state;
    vref_state_e       w_nxt;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_ldo_en;
    logic              r_vref_en;
    logic [1:0]        r_sc_mode;
    logic              r_ready;
    logic              r_terr;

    vref_sync2 u_bg_sync (
        .vref_pclk  (vref_pclk),
        .vref_rst_n (vref_rst_n),
        .i_d        (bg_flag),
        .o_q        (w_bg_s)
    );

`ifdef VREF_SEQ_BG_MON_EN
    localparam int               MON_W    = (BG_MON_LOW_CYC < 2) ? 1 : $clog2(BG_MON_LOW_CYC);
    localparam logic [MON_W-1:0] MON_LAST = MON_W'(BG_MON_LOW_CYC - 1);

    logic [MON_W-1:0] r_mon_cnt;

    // Count consecutive bg-low samples while ON; any high sample restarts the run.
    always_ff @(posedge vref_pclk or negedge vref_rst_n) begin
        if (!vref_rst_n)
            r_mon_cnt <= '0;
        else if (r_state != ST_ON || w_bg_s)
            r_mon_cnt <= '0;
        else if (r_mon_cnt != MON_LAST)
            r_mon_cnt <= r_mon_cnt + 1'b1;
    end
`endif

    // Next-state decode; a dropped req_on outranks every other exit from the up states.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_OFF:     if (req_on) w_nxt = ST_LDO_UP;
            ST_LDO_UP:  if (r_cnt == LDO_LAST) w_nxt = ST_VREF_UP;
            ST_VREF_UP: begin
                if (w_bg_s)                 w_nxt = ST_ON;
                else if (r_cnt == BG_LAST)  w_nxt = ST_ERR;
            end
            ST_ON: begin
`ifdef VREF_SEQ_BG_MON_EN
                if (!w_bg_s && r_mon_cnt == MON_LAST) w_nxt = ST_ERR;
`endif
            end
            ST_PWR_DN:  if (r_cnt == DN_LAST) w_nxt = ST_OFF;
            ST_ERR:     if (err_clr) w_nxt = ST_OFF;
            default:    w_nxt = ST_OFF;
        endcase
        if (!req_on && (r_state inside {ST_LDO_UP, ST_VREF_UP, ST_ON}))
            w_nxt = ST_PWR_DN;
    end

    // Phase counter: restarts on every state change, otherwise counts up and saturates.
    always_ff @(posedge vref_pclk or negedge vref_rst_n) begin
        if (!vref_rst_n)
            r_cnt <= '0;
        else if (w_nxt != r_state)
            r_cnt <= '0;
        else if (r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
    end

    // State and outputs registered together so outputs follow the state they describe.
    always_ff @(posedge vref_pclk or negedge vref_rst_n) begin
        if (!vref_rst_n) begin
            r_state   <= ST_OFF;
            r_ldo_en  <= 1'b0;
            r_vref_en <= 1'b0;
            r_sc_mode <= 2'b00;
            r_ready   <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_ldo_en  <= (w_nxt inside {ST_LDO_UP, ST_VREF_UP, ST_ON, ST_PWR_DN});
            r_vref_en <= (w_nxt inside {ST_VREF_UP, ST_ON});
            r_sc_mode <= (w_nxt == ST_ON) ? req_sc_mode : 2'b00;
            r_ready   <= (w_nxt == ST_ON);
            r_terr    <= (w_nxt == ST_ERR);
        end
    end

    assign ldo_en_o    = r_ldo_en;
    assign vref_en_o   = r_vref_en;
    assign sc_mode_o   = r_sc_mode;
    assign vref_ready  = r_ready;
    assign timeout_err = r_terr;
    assign seq_state   = r_state;

endmodule
